// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants for the GPR write-back path.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the register-file geometry and the fixed requester indices used
// by the write-back arbiter and its neighbours.
package gpr_wb_arbiter_pkg;

  localparam int GPR_AW  = 5;
  localparam int GPR_DW  = 32;
  localparam int GPR_NUM = 32;

  // Requester slots on the write-back arbiter.
  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

endpackage

// File: rtl/gpr_wb_arbiter_rr.sv
// Generic round-robin picker: first set request at or after ptr wins.
// Latency: purely combinational.
// Backpressure: none; the caller gates req to suppress grants.
//
// Ports:
//   req  - request bits, one per slot
//   ptr  - highest-priority slot this cycle (0..N-1)
//   gnt  - one-hot grant (all zero when no request)
//   idx  - index of the granted slot (0 when none)
//   any  - at least one request was granted
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk ptr, ptr+1, ... wrapping at N; the first hit wins.
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR file's single write port.
// Latency: grant at edge N, write port driven during cycle N+1.
// Backpressure: stall freezes grants; the write port itself never stalls.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/addr/data   - packed per-requester write requests
//   req_ready             - one-hot combinational grant
//   stall                 - suppress all grants this cycle
//   reg_write/waddr/wdata - registered register-file write port
//   pending               - bit r set while a write to r is outstanding
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = GPR_AW,
  parameter int DW   = GPR_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 stall,
  output logic                 reg_write,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  output logic [GPR_NUM-1:0]   pending
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic            gany;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   gdata;

  // Reset and stall both mask the requests, so no grant (and hence no ptr
  // movement or output load) can happen in either condition.
  assign arb_req = (stall || !rst_n) ? '0 : req_valid;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready = gnt;
  assign gaddr     = req_addr[int'(gidx)*AW +: AW];
  assign gdata     = req_data[int'(gidx)*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gany) begin
      ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  // r0 requests are consumed but never turn into a register-file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else if (gany) begin
      reg_write <= (gaddr != '0);
      waddr     <= gaddr;
      wdata     <= gdata;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // A register is pending from the cycle its request appears until the
  // cycle its write is on the port. Bit 0 is never set.
  always_comb begin
    pending = '0;
    for (int r = 1; r < GPR_NUM; r++) begin
      pending[r] = reg_write && (int'(waddr) == r);
      for (int i = 0; i < NREQ; i++) begin
        if (rst_n && req_valid[i] && (int'(req_addr[i*AW +: AW]) == r)) begin
          pending[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
  import gpr_wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = GPR_AW;
  localparam int DW   = GPR_DW;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                stall;
  logic                reg_write;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [GPR_NUM-1:0]  pending;

  gpr_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .reg_write (reg_write),
    .waddr     (waddr),
    .wdata     (wdata),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: round-robin pointer and the write-port registers.
  int           m_ptr;
  logic         m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [AW+DW:0] sb_q[$];

  // Register-file image built from what the DUT actually writes.
  logic [DW-1:0] rf [GPR_NUM];
  initial for (int r = 0; r < GPR_NUM; r++) rf[r] = '0;
  always @(posedge clk) if (reg_write) rf[waddr] <= wdata;

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    sb_q.delete();
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  // One cycle: check combinational outputs, predict the registered result,
  // clock, then compare. With drop set, a granted requester retires.
  task automatic step(input bit drop);
    logic [NREQ-1:0]    eg;
    logic [GPR_NUM-1:0] ep;
    logic [AW+DW:0]     e;
    int k;
    k  = -1;
    eg = '0;
    ep = '0;
    #1;
    if (rst_n && !stall) begin
      for (int off = 0; off < NREQ; off++) begin
        int j;
        j = (m_ptr + off) % NREQ;
        if (k < 0 && req_valid[j]) k = j;
      end
    end
    if (k >= 0) eg[k] = 1'b1;
    for (int r = 1; r < GPR_NUM; r++) begin
      if (m_we && int'(m_addr) == r) ep[r] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && int'(req_addr[i*AW +: AW]) == r) ep[r] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("pending", 64'(pending), 64'(ep));
    if (k >= 0) begin
      m_addr = req_addr[k*AW +: AW];
      m_data = req_data[k*DW +: DW];
      m_we   = (m_addr != '0);
      m_ptr  = (k + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    sb_q.push_back({m_we, m_addr, m_data});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("reg_write", 64'(reg_write), 64'(e[AW+DW]));
    chk("waddr", 64'(waddr), 64'(e[AW+DW-1:DW]));
    chk("wdata", 64'(wdata), 64'(e[DW-1:0]));
    if (drop && k >= 0) req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    model_reset();

    // 1. Reset with every requester asking.
    set_req(WB_ALU,    1'b1, 5'd1, 32'h1);
    set_req(WB_LOAD,   1'b1, 5'd2, 32'h2);
    set_req(WB_MULDIV, 1'b1, 5'd3, 32'h3);
    #3;
    do_reset();
    req_valid = '0;

    // 2. Single ALU write to r5, then two idle cycles for pending to clear.
    set_req(WB_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b1);
    chk("single_pending5_n1", 64'(pending[5]), 64'd1);
    step(1'b1);
    step(1'b1);
    chk("single_pending5_n2", 64'(pending[5]), 64'd0);

    // 3. Round-robin with everyone valid from reset.
    set_req(WB_ALU,    1'b1, 5'd1, 32'hA0);
    set_req(WB_LOAD,   1'b1, 5'd2, 32'hA1);
    set_req(WB_MULDIV, 1'b1, 5'd3, 32'hA2);
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b0);
    req_valid = '0;
    step(1'b0);

    // 4. Load unit writes r0: granted, no write.
    set_req(WB_LOAD, 1'b1, 5'd0, 32'h12345678);
    step(1'b1);
    chk("r0_pending0", 64'(pending[0]), 64'd0);
    step(1'b1);

    // 5. Stall with two writers to r7, then release.
    stall = 1'b1;
    set_req(WB_ALU,  1'b1, 5'd7, 32'h1);
    set_req(WB_LOAD, 1'b1, 5'd7, 32'h2);
    step(1'b1);
    step(1'b1);
    stall = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b1);
    chk("dup_r7_final", 64'(rf[7]), 64'h2);

    // 6. Reset right after a grant to r9.
    set_req(WB_ALU, 1'b1, 5'd9, 32'h99);
    step(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", 64'(reg_write), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_req(WB_ALU,    1'b1, 5'd10, 32'hB0);
    set_req(WB_LOAD,   1'b1, 5'd11, 32'hB1);
    set_req(WB_MULDIV, 1'b1, 5'd12, 32'hB2);
    for (int c = 0; c < 4; c++) step(1'b1);
    chk("midrst_r9_unwritten", 64'(rf[9]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
